// File: rtl/sync_burst_gen.sv
// Wake-up/sync front end: arms on wake_up, waits a bounded window for comp_out,
// then emits a fixed-length divided data clock with per-bit strobe and T_0/T_1 pattern.
module sync_burst_gen #(
  parameter int unsigned CLK_DIV       = 100,
  parameter int unsigned NUM_BITS      = 1000,
  parameter int unsigned TIMEOUT_TICKS = 20000,
  parameter int unsigned PREAMBLE_BITS = 432,
  parameter int unsigned CNT_W         = 20
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             wake_up,
  input  logic             comp_out,
  input  logic [1:0]       mode,
  input  logic             data_in,
  output logic             WU_valid,
  output logic             data_clk_enb,
  output logic             data_clk,
  output logic             bit_strobe,
  output logic [CNT_W-1:0] bit_idx,
  output logic             T_0,
  output logic             T_1,
  output logic             timeout,
  output logic             done
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] TIM_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(NUM_BITS);
  localparam logic [CNT_W-1:0] PRE_END   = CNT_W'(PREAMBLE_BITS);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t           state, state_n;
  logic [2:0]       wu_h, co_h;
  logic [CNT_W-1:0] tim_cnt, tim_n;
  logic [CNT_W-1:0] div_cnt, div_n;
  logic [CNT_W-1:0] bit_cnt, bit_n;
  logic [CNT_W-1:0] idx_n;
  logic [1:0]       mode_q, mode_n;
  logic             wu_valid_n, enb_n, dclk_n, strobe_n, t0_n, t1_n, timeout_n, done_n;
  logic             wu_edge, co_edge;

  assign wu_edge = (wu_h[2:1] == 2'b01);
  assign co_edge = (co_h[2:1] == 2'b01);

  always_ff @(posedge clki) begin
    if (!rst_n) begin
      state        <= IDLE;
      wu_h         <= '0;
      co_h         <= '0;
      tim_cnt      <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      mode_q       <= '0;
      WU_valid     <= 1'b0;
      data_clk_enb <= 1'b0;
      data_clk     <= 1'b0;
      bit_strobe   <= 1'b0;
      bit_idx      <= '0;
      T_0          <= 1'b0;
      T_1          <= 1'b0;
      timeout      <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      wu_h         <= {wu_h[1:0], wake_up};
      co_h         <= {co_h[1:0], comp_out};
      tim_cnt      <= tim_n;
      div_cnt      <= div_n;
      bit_cnt      <= bit_n;
      mode_q       <= mode_n;
      WU_valid     <= wu_valid_n;
      data_clk_enb <= enb_n;
      data_clk     <= dclk_n;
      bit_strobe   <= strobe_n;
      bit_idx      <= idx_n;
      T_0          <= t0_n;
      T_1          <= t1_n;
      timeout      <= timeout_n;
      done         <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    tim_n      = tim_cnt;
    div_n      = div_cnt;
    bit_n      = bit_cnt;
    mode_n     = mode_q;
    wu_valid_n = WU_valid;
    enb_n      = data_clk_enb;
    dclk_n     = data_clk;
    strobe_n   = 1'b0;
    idx_n      = bit_idx;
    t0_n       = T_0;
    t1_n       = T_1;
    timeout_n  = 1'b0;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        if (wu_edge) begin
          state_n    = ARMED;
          wu_valid_n = 1'b1;
          tim_n      = '0;
        end
      end

      ARMED: begin
        tim_n = tim_cnt + 1'b1;
        // Sync edge wins over both a re-arm and expiry in the same cycle.
        if (co_edge) begin
          state_n    = RUN;
          wu_valid_n = 1'b0;
          enb_n      = 1'b1;
          dclk_n     = 1'b0;
          div_n      = HALF_LAST;
          bit_n      = '0;
          mode_n     = mode;
        end else if (wu_edge) begin
          tim_n = '0;
        end else if (tim_cnt == TIM_LAST) begin
          state_n    = IDLE;
          wu_valid_n = 1'b0;
          timeout_n  = 1'b1;
          tim_n      = '0;
        end
      end

      RUN: begin
        if (div_cnt == HALF_LAST) begin
          div_n = '0;
          if (data_clk) begin
            dclk_n = 1'b0;
            if (bit_cnt == BIT_END) begin
              state_n = IDLE;
              enb_n   = 1'b0;
              done_n  = 1'b1;
              t0_n    = 1'b0;
              t1_n    = 1'b0;
            end
          end else begin
            dclk_n   = 1'b1;
            strobe_n = 1'b1;
            idx_n    = bit_cnt;
            bit_n    = bit_cnt + 1'b1;
            if (bit_cnt < PRE_END) begin
              t1_n = 1'b0;
              t0_n = 1'b0;
            end else begin
              // T_1 is held at 0 through the preamble, so the first toggle yields 1.
              case (mode_q)
                2'b00:   begin t1_n = ~T_1;    t0_n = 1'b0; end
                2'b01:   begin t1_n = 1'b1;    t0_n = 1'b0; end
                2'b10:   begin t1_n = data_in; t0_n = 1'b0; end
                default: begin t1_n = ~T_1;    t0_n = T_1;  end
              endcase
            end
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
